transition_gen: RTL

Debounced push-button front end that produces the `transition` pulse consumed by the L-state toggle block on the DE0 board. It synchronises the raw active-low key and filters contact bounce. On each confirmed press it emits exactly one single-cycle `transition` pulse, so the downstream toggle flips once per physical press.

---
 rtl/transition_gen_pkg.sv | 22 ++
 rtl/transition_gen_sync_2ff.sv | 25 ++
 rtl/transition_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/transition_gen_pkg.sv
// Shared FSM encodings and default timing constants for the push-button debouncer.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Optional feature macro used by the top: TRANSITION_REPEAT_EN.
package transition_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // 10 ms debounce and 0.5 s auto-repeat at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_CYCLES   = 25000000;
  localparam int DEF_CNT_W           = 20;

  function automatic logic is_pressed(input state_t s);
    return (s == ST_HELD) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/transition_gen_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input, reset value selectable.
// Latency: 2 cycles. Backpressure: none, free-running.
// Reusable for every DE0 key; keys are active-low so their instances reset to 1.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/transition_gen.sv
// transition_gen: debounced key front end, one-cycle transition pulse per accepted press.
// Latency: DEBOUNCE_CYCLES+2 edges from first pressed sample to pulse. Backpressure: none.
// Optional auto-repeat while held when TRANSITION_REPEAT_EN is defined.
module transition_gen
  import transition_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic button_n,
  output logic transition,
  output logic pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || CNT_W < $clog2(DEBOUNCE_CYCLES + 1) || REPEAT_CYCLES < 1)
  begin : g_bad_params
    $error("transition_gen: illegal DEBOUNCE_CYCLES / CNT_W / REPEAT_CYCLES");
  end

  logic             btn_s;
  logic             key;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_fire;
  logic             pulse_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (button_n),
    .q   (btn_s)
  );

  assign key = ~btn_s;

  // Every state entry clears cnt, so it can never run past CNT_LAST
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = ST_HELD;
          cnt_nxt    = '0;
          press_fire = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!key) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef TRANSITION_REPEAT_EN
  localparam int             REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic             rep_fire;

  // Counts only while staying in HELD; holds through a release bounce, clears once released
  always_comb begin
    rep_nxt  = rep_cnt;
    rep_fire = 1'b0;
    if (state == ST_HELD && state_nxt == ST_HELD) begin
      if (rep_cnt == REP_LAST) begin
        rep_fire = 1'b1;
        rep_nxt  = '0;
      end else begin
        rep_nxt = rep_cnt + REP_W'(1);
      end
    end else if (state_nxt == ST_IDLE || state_nxt == ST_PRESS_WAIT) begin
      rep_nxt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) rep_cnt <= '0;
    else     rep_cnt <= rep_nxt;
  end

  assign pulse_nxt = press_fire | rep_fire;
`else
  assign pulse_nxt = press_fire;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      transition <= 1'b0;
      pressed    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      transition <= pulse_nxt;
      pressed    <= is_pressed(state_nxt);
    end
  end

endmodule
